instr_encode_loader: RTL

INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

---
 rtl/instr_encode_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_encode_loader.sv
// Instruction encoder / program loader.
// Accepts decoded instruction fields over a valid/ready handshake, encodes each
// one into a MIPS-style 32-bit word, and writes the words to consecutive
// instruction-memory addresses starting at BASE_ADDR.
module instr_encode_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned DEPTH     = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  input  logic        last_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [7:0]  count_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] ptr_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  count_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        last_q;

  logic [31:0] word_d;
  logic        legal_d;
  logic        full_d;

  // Encode the presented fields into an instruction word; kind 7 is illegal.
  always_comb begin
    word_d  = '0;
    legal_d = 1'b1;
    case (kind_i)
      3'd0:    word_d = {6'd0,  rs_i, rt_i, rd_i, shamt_i, funct_i};
      3'd1:    word_d = {6'd8,  rs_i, rt_i, imm_i};
      3'd2:    word_d = {6'd10, rs_i, rt_i, imm_i};
      3'd3:    word_d = {6'd4,  rs_i, rt_i, imm_i};
      3'd4:    word_d = {6'd35, rs_i, rt_i, imm_i};
      3'd5:    word_d = {6'd43, rs_i, rt_i, imm_i};
      3'd6:    word_d = {6'd2,  target_i};
      default: legal_d = 1'b0;
    endcase
  end

  // Program buffer is full once DEPTH words have been written.
  always_comb begin
    full_d = (32'(count_q) >= DEPTH);
  end

  // Load-control FSM; every output is a register updated alongside the state.
  // A full buffer takes priority over an illegal kind so the load always ends.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE_ADDR;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_LOAD;
            ptr_q   <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (valid_i) begin
            if (full_d) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (!legal_d) begin
              err_q <= 1'b1;
              if (last_i) begin
                state_q <= S_DONE;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              addr_q  <= ptr_q;
              wdata_q <= word_d;
              we_q    <= 1'b1;
              last_q  <= last_i;
              ready_q <= 1'b0;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we_q    <= 1'b0;
          count_q <= count_q + 8'd1;
          ptr_q   <= ptr_q + 32'd4;
          if (last_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
